// File: rtl/access_pkg.sv
// Shared types, widths and helpers for the UID access controller.
package access_pkg;

  localparam int UID_W   = 32;
  localparam int FAIL_W  = 4;
  localparam int GRANT_W = 16;
  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    GRANT   = 3'd2,
    DENY    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [GRANT_W-1:0] sat_inc(input logic [GRANT_W-1:0] v);
    logic [GRANT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/access_ctrl_chk.sv
// Property checker for access_ctrl outputs; instantiate alongside the controller.
module access_ctrl_chk
  import access_pkg::*;
#(
  parameter logic [FAIL_W-1:0] MAX_FAILS = 4'd3
) (
  input logic              clk,
  input logic              rst,
  input logic              uid_ready,
  input logic              unlock,
  input logic              deny,
  input logic              locked_out,
  input logic [FAIL_W-1:0] fail_count
);

  a_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({unlock, deny, locked_out}));

  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    (unlock || deny || locked_out) |-> !uid_ready);

  a_fail_max: assert property (@(posedge clk) disable iff (rst)
    fail_count <= MAX_FAILS);

endmodule

// File: rtl/access_timer.sv
// Loadable down-counter that parks at zero; zero flag decoded from the count register.
module access_timer
  import access_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != 32'd0)) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 32'd0);

endmodule

// File: rtl/access_ctrl.sv
// UID sequencing controller: accept UID, query allow-list, drive timed
// unlock / deny / lockout outputs, track consecutive misses and grants.
module access_ctrl
  import access_pkg::*;
#(
  parameter logic [TIMER_W-1:0] UNLOCK_CYCLES  = 32'd50_000_000,
  parameter logic [TIMER_W-1:0] DENY_CYCLES    = 32'd10_000_000,
  parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = 32'd500_000_000,
  parameter logic [FAIL_W-1:0]  MAX_FAILS      = 4'd3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uid_valid,
  input  logic [UID_W-1:0]   uid,
  output logic               uid_ready,
  output logic [UID_W-1:0]   lut_uid,
  input  logic               lut_allowed,
  output logic               unlock,
  output logic               deny,
  output logic               locked_out,
  output logic [FAIL_W-1:0]  fail_count,
  output logic [GRANT_W-1:0] grant_total
);

  state_t             state_r, state_s;
  logic [UID_W-1:0]   lut_uid_r, lut_uid_s;
  logic [FAIL_W-1:0]  fail_r, fail_s;
  logic [GRANT_W-1:0] grant_r, grant_s;
  logic               ready_r, unlock_r, deny_r, locked_r;
  logic               tmr_load_s, tmr_en_s, tmr_zero_s;
  logic [TIMER_W-1:0] tmr_value_s;
  logic [FAIL_W:0]    fail_inc_s;

  access_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .en         (tmr_en_s),
    .load_value (tmr_value_s),
    .zero       (tmr_zero_s)
  );

  // Widened so the compare against MAX_FAILS cannot wrap at 15.
  assign fail_inc_s = {1'b0, fail_r} + 5'd1;

  // Next-state, counter updates and timer control.
  always_comb begin
    state_s     = state_r;
    lut_uid_s   = lut_uid_r;
    fail_s      = fail_r;
    grant_s     = grant_r;
    tmr_load_s  = 1'b0;
    tmr_value_s = 32'd0;
    tmr_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (uid_valid) begin
          lut_uid_s = uid;
          state_s   = CHECK;
        end else begin
          state_s   = IDLE;
        end
      end
      CHECK: begin
        tmr_load_s = 1'b1;
        if (lut_allowed) begin
          fail_s      = 4'd0;
          grant_s     = sat_inc(grant_r);
          tmr_value_s = UNLOCK_CYCLES - 32'd1;
          state_s     = GRANT;
        end else if (fail_inc_s == {1'b0, MAX_FAILS}) begin
          fail_s      = MAX_FAILS;
          tmr_value_s = LOCKOUT_CYCLES - 32'd1;
          state_s     = LOCKOUT;
        end else begin
          fail_s      = fail_inc_s[FAIL_W-1:0];
          tmr_value_s = DENY_CYCLES - 32'd1;
          state_s     = DENY;
        end
      end
      GRANT, DENY: begin
        tmr_en_s = 1'b1;
        if (tmr_zero_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      LOCKOUT: begin
        tmr_en_s = 1'b1;
        if (tmr_zero_s) begin
          fail_s  = 4'd0;
          state_s = IDLE;
        end else begin
          state_s = LOCKOUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lut_uid_r <= 32'd0;
      fail_r    <= 4'd0;
      grant_r   <= 16'd0;
      ready_r   <= 1'b1;
      unlock_r  <= 1'b0;
      deny_r    <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      lut_uid_r <= lut_uid_s;
      fail_r    <= fail_s;
      grant_r   <= grant_s;
      ready_r   <= (state_s == IDLE);
      unlock_r  <= (state_s == GRANT);
      deny_r    <= (state_s == DENY);
      locked_r  <= (state_s == LOCKOUT);
    end
  end

  assign uid_ready   = ready_r;
  assign lut_uid     = lut_uid_r;
  assign unlock      = unlock_r;
  assign deny        = deny_r;
  assign locked_out  = locked_r;
  assign fail_count  = fail_r;
  assign grant_total = grant_r;

endmodule

// File: tb/tb_access_ctrl.sv
// Directed self-checking bench for access_ctrl with a two-entry allow-list.
module tb_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        uid_valid;
  logic [31:0] uid;
  logic        uid_ready;
  logic [31:0] lut_uid;
  logic        lut_allowed;
  logic        unlock;
  logic        deny;
  logic        locked_out;
  logic [3:0]  fail_count;
  logic [15:0] grant_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Allow-list lookup: UID0 and UID1.
  assign lut_allowed = (lut_uid == 32'hDEADBEEF) || (lut_uid == 32'h12345678);

  access_ctrl #(
    .UNLOCK_CYCLES  (32'd4),
    .DENY_CYCLES    (32'd3),
    .LOCKOUT_CYCLES (32'd5),
    .MAX_FAILS      (4'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uid_valid   (uid_valid),
    .uid         (uid),
    .uid_ready   (uid_ready),
    .lut_uid     (lut_uid),
    .lut_allowed (lut_allowed),
    .unlock      (unlock),
    .deny        (deny),
    .locked_out  (locked_out),
    .fail_count  (fail_count),
    .grant_total (grant_total)
  );

  access_ctrl_chk #(.MAX_FAILS(4'd3)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .uid_ready  (uid_ready),
    .unlock     (unlock),
    .deny       (deny),
    .locked_out (locked_out),
    .fail_count (fail_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 grant, 1 deny, 2 lockout. Called and returns at a negedge.
  task automatic run_txn(input logic [31:0] id, input int kind, input int n,
                         input logic [3:0] fail_in, input logic [3:0] fail_out,
                         input logic [15:0] grants_out);
    uid_valid = 1'b1;
    uid       = id;
    @(posedge clk);
    #1;
    uid_valid = 1'b0;
    uid       = 32'h0;
    @(negedge clk);
    chk("check_ready", {31'd0, uid_ready}, 32'd0);
    chk("check_lut_uid", lut_uid, id);
    chk("check_outs", {29'd0, unlock, deny, locked_out}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_ready", {31'd0, uid_ready}, 32'd0);
      chk("unlock", {31'd0, unlock}, {31'd0, kind == 0});
      chk("deny", {31'd0, deny}, {31'd0, kind == 1});
      chk("locked_out", {31'd0, locked_out}, {31'd0, kind == 2});
      chk("busy_fail_count", {28'd0, fail_count}, {28'd0, fail_in});
    end
    @(negedge clk);
    chk("idle_ready", {31'd0, uid_ready}, 32'd1);
    chk("idle_outs", {29'd0, unlock, deny, locked_out}, 32'd0);
    chk("idle_fail_count", {28'd0, fail_count}, {28'd0, fail_out});
    chk("idle_grant_total", {16'd0, grant_total}, {16'd0, grants_out});
  endtask

  initial begin
    rst       = 1'b1;
    uid_valid = 1'b0;
    uid       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, uid_ready}, 32'd1);
    chk("rst_outs", {29'd0, unlock, deny, locked_out}, 32'd0);
    chk("rst_fail_count", {28'd0, fail_count}, 32'd0);
    chk("rst_grant_total", {16'd0, grant_total}, 32'd0);
    chk("rst_lut_uid", lut_uid, 32'd0);

    // Grant, deny, deny, lockout, deny after lockout.
    run_txn(32'hDEADBEEF, 0, 4, 4'd0, 4'd0, 16'd1);
    run_txn(32'hCAFEF00D, 1, 3, 4'd1, 4'd1, 16'd1);
    run_txn(32'hCAFEF00D, 1, 3, 4'd2, 4'd2, 16'd1);
    run_txn(32'h0BADF00D, 2, 5, 4'd3, 4'd0, 16'd1);
    run_txn(32'hCAFEF00D, 1, 3, 4'd1, 4'd1, 16'd1);

    // Hit clears fail count; then miss, miss, hit on the second allow-list entry.
    run_txn(32'hDEADBEEF, 0, 4, 4'd0, 4'd0, 16'd2);
    run_txn(32'h11111111, 1, 3, 4'd1, 4'd1, 16'd2);
    run_txn(32'h22222222, 1, 3, 4'd2, 4'd2, 16'd2);
    run_txn(32'h12345678, 0, 4, 4'd0, 4'd0, 16'd3);

    // uid_valid held through GRANT: exactly one re-accept once back in IDLE.
    uid_valid = 1'b1;
    uid       = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_check_unlock", {31'd0, unlock}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_unlock", {31'd0, unlock}, 32'd1);
      chk("hold_ready", {31'd0, uid_ready}, 32'd0);
      chk("hold_grant_total", {16'd0, grant_total}, 32'd4);
    end
    @(negedge clk);
    chk("hold_idle_ready", {31'd0, uid_ready}, 32'd1);
    chk("hold_idle_unlock", {31'd0, unlock}, 32'd0);
    chk("hold_idle_grant_total", {16'd0, grant_total}, 32'd4);
    @(posedge clk);
    #1;
    uid_valid = 1'b0;
    uid       = 32'h0;
    @(negedge clk);
    chk("rehold_check_ready", {31'd0, uid_ready}, 32'd0);
    chk("rehold_check_unlock", {31'd0, unlock}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rehold_unlock", {31'd0, unlock}, 32'd1);
      chk("rehold_grant_total", {16'd0, grant_total}, 32'd5);
    end
    @(negedge clk);
    chk("rehold_idle_ready", {31'd0, uid_ready}, 32'd1);
    chk("rehold_idle_unlock", {31'd0, unlock}, 32'd0);

    // Reset during the second unlock cycle.
    run_txn(32'hCAFEF00D, 1, 3, 4'd1, 4'd1, 16'd5);
    uid_valid = 1'b1;
    uid       = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    uid_valid = 1'b0;
    uid       = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_unlock1", {31'd0, unlock}, 32'd1);
    @(negedge clk);
    chk("mid_unlock2", {31'd0, unlock}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_unlock", {31'd0, unlock}, 32'd0);
    chk("mid_rst_ready", {31'd0, uid_ready}, 32'd1);
    chk("mid_rst_grant_total", {16'd0, grant_total}, 32'd0);
    chk("mid_rst_fail_count", {28'd0, fail_count}, 32'd0);
    chk("mid_rst_lut_uid", lut_uid, 32'd0);

    // Normal grant after the abort.
    run_txn(32'hDEADBEEF, 0, 4, 4'd0, 4'd0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
